sat_accum_unit: RTL and testbench
=================================

SAT_ACCUM_UNIT -- requirements
Module: sat_accum_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous to clk, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-005 count  input  4  number of operands in the job (0-15), sampled with start.
REQ-006 in_valid  input  1  in_data/in_sub hold a valid operand.
REQ-007 in_data  input  16  signed two's-complement operand.
REQ-008 in_sub  input  1  1 = subtract operand from accumulator, 0 = add.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_data  output  16  signed saturated accumulation result.
REQ-012 out_ovfl  output  1  sticky flag: at least one step of the job saturated.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 In IDLE with start=1 and count!=0, the block SHALL clear the accumulator to 0x0000, clear the sticky flag, load remaining=count and enter ACCUM on the next edge.
REQ-017 In IDLE with start=1 and count=0, the block SHALL clear the accumulator and the sticky flag and enter DONE directly.
REQ-018 In IDLE with start=0, and for start in any state other than IDLE, the block SHALL ignore start.
REQ-019 in_ready SHALL be high only in ACCUM; an operand transfers on a clock edge where in_valid and in_ready are both high.
REQ-020 On each transfer, the block SHALL compute the exact 17-bit signed value acc+in_data (in_sub=0) or acc-in_data (in_sub=1).
REQ-021 If that value is greater than 32767, the accumulator SHALL load 0x7FFF; if it is less than -32768, the accumulator SHALL load 0x8000; otherwise it SHALL load the low 16 bits.
REQ-022 Whenever a transfer clamps, the sticky flag SHALL be set; the flag SHALL clear only on a new job start or on reset.
REQ-023 Subtracting 0x8000 SHALL follow REQ-020/021 exactly; for example, 0x0000-0x8000 clamps to 0x7FFF and sets the flag.
REQ-024 On each transfer, remaining SHALL decrement; the transfer with remaining=1 SHALL move the FSM to DONE on the same edge.
REQ-025 Each transfer has a latency of one cycle: the updated accumulator is visible on out_data in the next cycle.
REQ-026 In ACCUM with in_valid=0, the block SHALL hold all state with no timeout.
REQ-027 In DONE, out_valid SHALL be 1, out_data SHALL equal the accumulator and out_ovfl SHALL equal the sticky flag.
REQ-028 In DONE, the result SHALL hold stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-029 Outside DONE, out_valid SHALL be 0, while out_data and out_ovfl SHALL show the live accumulator and the live sticky flag.
REQ-030 A start pulse coincident with the DONE-to-IDLE edge SHALL be ignored; the earliest accepted start is in the first IDLE cycle.

Reset
REQ-031 On a clock edge with rst=1, the block SHALL enter IDLE from any state, including mid-job.
REQ-032 Reset SHALL clear the accumulator to 0x0000, the sticky flag to 0 and remaining to 0.
REQ-033 After reset: in_ready=0, out_valid=0, out_data=0x0000, out_ovfl=0, busy=0.
REQ-034 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- count=3; ops +0x0005, +0x0003, sub 0x0002 -> out_data=0x0006, out_ovfl=0, out_valid asserts the cycle after the 3rd transfer.
- count=2; ops +0x7000, +0x2000 -> out_data=0x7FFF, out_ovfl=1.
- count=2; ops sub 0x8000, then +0xFFFF -> 0x7FFF then 0x7FFE, out_ovfl=1 (sticky persists after the in-range 2nd step).
- count=0 with start -> DONE next cycle; out_data=0x0000, out_ovfl=0; out_ready held low for 5 cycles -> result stays stable and out_valid stays 1.
- count=4, rst=1 after the 2nd transfer -> next cycle IDLE, busy=0, out_data=0x0000, in_ready=0; a fresh job with count=1, +0x0001 -> 0x0001.
- in_valid toggled 1/0 every cycle during a count=5 job of +0x0001 each -> out_data=0x0005, and exactly 5 transfers counted.

Source files
------------

// File: rtl/sat_accum_unit.sv
// sat_accum_unit: job-based signed 16-bit accumulator with saturation and sticky overflow.
module sat_accum_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  count,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_sub,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_ovfl,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   rem, rem_next;
  logic [DW-1:0]   acc_next;
  logic            ovfl_next;
  logic [DW:0]     sum;
  logic [DW-1:0]   sat;
  logic            clamp;

  // Exact 17-bit sum/difference and its saturated 16-bit form.
  always_comb begin
    sum   = in_sub ? ({out_data[DW-1], out_data} - {in_data[DW-1], in_data})
                   : ({out_data[DW-1], out_data} + {in_data[DW-1], in_data});
    clamp = sum[DW] ^ sum[DW-1];
    if (!clamp)
      sat = sum[DW-1:0];
    else if (sum[DW])
      sat = 16'h8000;
    else
      sat = 16'h7FFF;
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_next = state;
    acc_next   = out_data;
    ovfl_next  = out_ovfl;
    rem_next   = rem;
    unique case (state)
      IDLE: begin
        if (start) begin
          acc_next  = '0;
          ovfl_next = 1'b0;
          if (count != '0) begin
            rem_next   = count;
            state_next = ACCUM;
          end else begin
            rem_next   = '0;
            state_next = DONE;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_next = sat;
          if (clamp) ovfl_next = 1'b1;
          rem_next = rem - CW'(1);
          if (rem == CW'(1)) state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered status outputs; reset has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      out_data  <= '0;
      out_ovfl  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      rem       <= rem_next;
      out_data  <= acc_next;
      out_ovfl  <= ovfl_next;
      in_ready  <= (state_next == ACCUM);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_sat_accum_unit.sv
// Directed self-checking bench for sat_accum_unit.
module tb_sat_accum_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_sub;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ovfl;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sat_accum_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovfl  (out_ovfl),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; observe #1 after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic sub, input logic [15:0] d);
    in_valid = 1'b1;
    in_sub   = sub;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_job(input logic [3:0] n);
    start = 1'b1;
    count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int  xfers;
    int  cyc;
    bit  v;

    rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0;
    in_data = '0; in_sub = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0000);
    check("rst_out_ovfl", 32'(out_ovfl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Operands offered in IDLE must not transfer.
    in_valid = 1'b1; in_data = 16'h0011; tick(); in_valid = 1'b0;
    check("idle_no_xfer", 32'(out_data), 32'h0000);

    // Job 1: +5 +3 -2 = 6.
    begin_job(4'd3);
    check("j1_busy", 32'(busy), 32'd1);
    check("j1_in_ready", 32'(in_ready), 32'd1);
    op(1'b0, 16'h0005);
    check("j1_step1", 32'(out_data), 32'h0005);
    op(1'b0, 16'h0003);
    check("j1_step2", 32'(out_data), 32'h0008);
    check("j1_not_done", 32'(out_valid), 32'd0);
    op(1'b1, 16'h0002);
    check("j1_valid", 32'(out_valid), 32'd1);
    check("j1_data", 32'(out_data), 32'h0006);
    check("j1_ovfl", 32'(out_ovfl), 32'd0);
    check("j1_in_ready_done", 32'(in_ready), 32'd0);
    release_result();
    check("j1_idle_valid", 32'(out_valid), 32'd0);
    check("j1_idle_busy", 32'(busy), 32'd0);

    // Job 2: positive saturation.
    begin_job(4'd2);
    op(1'b0, 16'h7000);
    check("j2_step1", 32'(out_data), 32'h7000);
    check("j2_step1_ovfl", 32'(out_ovfl), 32'd0);
    op(1'b0, 16'h2000);
    check("j2_data", 32'(out_data), 32'h7FFF);
    check("j2_ovfl", 32'(out_ovfl), 32'd1);
    check("j2_valid", 32'(out_valid), 32'd1);
    release_result();

    // Job 3: 0 - 0x8000 clamps; sticky flag survives an in-range step.
    begin_job(4'd2);
    check("j3_ovfl_cleared", 32'(out_ovfl), 32'd0);
    op(1'b1, 16'h8000);
    check("j3_step1", 32'(out_data), 32'h7FFF);
    check("j3_step1_ovfl", 32'(out_ovfl), 32'd1);
    op(1'b0, 16'hFFFF);
    check("j3_data", 32'(out_data), 32'h7FFE);
    check("j3_ovfl", 32'(out_ovfl), 32'd1);
    check("j3_valid", 32'(out_valid), 32'd1);
    // Start coincident with the DONE-to-IDLE edge is ignored.
    start = 1'b1; count = 4'd1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("j3_start_ignored", 32'(busy), 32'd0);
    check("j3_live_ovfl_idle", 32'(out_ovfl), 32'd1);
    check("j3_live_data_idle", 32'(out_data), 32'h7FFE);

    // Job 4: negative saturation.
    begin_job(4'd2);
    op(1'b0, 16'h8000);
    check("j4_step1", 32'(out_data), 32'h8000);
    check("j4_step1_ovfl", 32'(out_ovfl), 32'd0);
    op(1'b0, 16'hFFFF);
    check("j4_data", 32'(out_data), 32'h8000);
    check("j4_ovfl", 32'(out_ovfl), 32'd1);
    release_result();

    // Job 5: count=0 goes straight to DONE and holds until out_ready.
    begin_job(4'd0);
    check("j5_valid", 32'(out_valid), 32'd1);
    check("j5_data", 32'(out_data), 32'h0000);
    check("j5_ovfl", 32'(out_ovfl), 32'd0);
    check("j5_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("j5_hold_valid", 32'(out_valid), 32'd1);
      check("j5_hold_data", 32'(out_data), 32'h0000);
    end
    release_result();
    check("j5_released", 32'(out_valid), 32'd0);

    // Job 6: reset mid-job, with start/in_valid also asserted, wins.
    begin_job(4'd4);
    op(1'b0, 16'h0001);
    op(1'b0, 16'h0001);
    check("j6_mid", 32'(out_data), 32'h0002);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 16'h0100;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("j6_rst_busy", 32'(busy), 32'd0);
    check("j6_rst_data", 32'(out_data), 32'h0000);
    check("j6_rst_in_ready", 32'(in_ready), 32'd0);
    check("j6_rst_valid", 32'(out_valid), 32'd0);
    begin_job(4'd1);
    op(1'b0, 16'h0001);
    check("j6_fresh_data", 32'(out_data), 32'h0001);
    check("j6_fresh_valid", 32'(out_valid), 32'd1);
    release_result();

    // Job 7: in_valid toggling; idle cycles must hold state.
    begin_job(4'd5);
    xfers = 0;
    cyc   = 0;
    v     = 1'b1;
    while (!out_valid && cyc < 30) begin
      in_valid = v; in_data = 16'h0001; in_sub = 1'b0;
      if (v && in_ready) xfers++;
      tick();
      v = !v;
      cyc++;
    end
    in_valid = 1'b0;
    check("j7_done_in_budget", 32'(out_valid), 32'd1);
    check("j7_data", 32'(out_data), 32'h0005);
    check("j7_xfers", 32'(xfers), 32'd5);
    check("j7_cycles", 32'(cyc), 32'd9);
    release_result();
    check("j7_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
